// File: rtl/clip_playback_sequencer.sv
// Sequences 16-bit audio clips from the sample ROM, one word per I2S frame.
// Latency: sample_valid 7 Clk after the LRCLK pin falling edge (3 + 1 + ROM_LAT + 1).
// No backpressure: a frame tick arriving mid-fetch is dropped and flagged as overrun.
module clip_playback_sequencer #(
  parameter int ADDR_W  = 11,
  parameter int CLIP_W  = 8,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 2,
  parameter logic [DATA_W-1:0] END_MARK = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              I2S_LRCLK,
  input  logic [2:0]        clip_sel,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [CLIP_W-1:0] offset;
  // Set once the last word of the region has been played; the next fetch
  // then behaves as an end marker without touching the ROM.
  logic              end_pend;
  logic [CNT_W-1:0]  cnt;
  logic              lr_s1, lr_s2, lr_s3;
  logic              frame_tick;
  logic              is_end;
  logic              in_fetch;

  // Two-flop synchronizer for the raw LRCLK pin plus one history flop for edge detect.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lr_s1 <= 1'b0;
      lr_s2 <= 1'b0;
      lr_s3 <= 1'b0;
    end else begin
      lr_s1 <= I2S_LRCLK;
      lr_s2 <= lr_s1;
      lr_s3 <= lr_s2;
    end
  end

  assign frame_tick = lr_s3 & ~lr_s2;
  assign is_end     = end_pend | (rom_q == END_MARK);
  assign in_fetch   = (state == FETCH) | (state == WAIT) | (state == CHECK);
  assign busy       = (state != IDLE);

  // Playback state machine: latch clip, fetch one word per frame, detect clip end.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      base         <= '0;
      offset       <= '0;
      end_pend     <= 1'b0;
      cnt          <= '0;
      rom_addr     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      if (frame_tick && in_fetch) begin
        overrun <= 1'b1;
      end
      if (stop) begin
        state    <= IDLE;
        sample   <= '0;
        rom_addr <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (play) begin
              base     <= ADDR_W'(clip_sel) << CLIP_W;
              offset   <= '0;
              end_pend <= 1'b0;
              overrun  <= 1'b0;
              state    <= ARMED;
            end
          end
          ARMED: begin
            if (frame_tick) begin
              state <= FETCH;
            end
          end
          FETCH: begin
            if (!end_pend) begin
              rom_addr <= base + ADDR_W'(offset);
            end
            cnt   <= CNT_W'(ROM_LAT - 1);
            state <= WAIT;
          end
          WAIT: begin
            if (cnt == '0) begin
              state <= CHECK;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          CHECK: begin
            if (is_end) begin
              // An empty clip (marker at offset 0) always ends so loop cannot spin.
              if (loop && (end_pend || offset != '0)) begin
                offset   <= '0;
                end_pend <= 1'b0;
                state    <= FETCH;
              end else begin
                done     <= 1'b1;
                rom_addr <= '0;
                state    <= IDLE;
              end
            end else begin
              sample       <= rom_q;
              sample_valid <= 1'b1;
              offset       <= offset + CLIP_W'(1);
              if (offset == '1) begin
                end_pend <= 1'b1;
              end
              state <= ARMED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clip_playback_sequencer.sv
module tb_clip_playback_sequencer;

  typedef struct packed {
    logic        is_done;
    logic [15:0] val;
  } ev_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        I2S_LRCLK = 1'b1;
  logic [2:0]  clip_sel = 3'd0;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [10:0] rom_addr;
  logic [15:0] rom_q = 16'h0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic        overrun;

  logic [15:0] mem [0:2047];
  logic [15:0] q1 = 16'h0;
  logic [10:0] prev_addr = 11'h0;
  ev_t         exp_ev [$];
  logic [10:0] exp_addr [$];
  ev_t         got_e;
  logic [10:0] got_a;
  int          n_cmp = 0;
  int          n_err = 0;

  clip_playback_sequencer dut (
    .Clk(Clk), .Reset(Reset), .I2S_LRCLK(I2S_LRCLK), .clip_sel(clip_sel),
    .play(play), .stop(stop), .loop(loop), .rom_addr(rom_addr), .rom_q(rom_q),
    .sample(sample), .sample_valid(sample_valid), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Two-cycle ROM model
  always @(posedge Clk) begin
    q1    <= mem[rom_addr];
    rom_q <= q1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: pops expected events and fetch addresses as the DUT produces them
  always @(negedge Clk) begin
    if (sample_valid || done) begin
      if (exp_ev.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got valid=%0b done=%0b sample=%h, required none",
                 sample_valid, done, sample);
      end else begin
        got_e = exp_ev.pop_front();
        check("event", {14'h0, sample_valid, done, (sample_valid ? sample : 16'h0)},
              {14'h0, ~got_e.is_done, got_e.is_done, (got_e.is_done ? 16'h0 : got_e.val)});
      end
    end
    if (rom_addr != prev_addr && rom_addr != 11'h0) begin
      if (exp_addr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_fetch: got rom_addr=%h, required none", rom_addr);
      end else begin
        got_a = exp_addr.pop_front();
        check("rom_addr", {21'h0, rom_addr}, {21'h0, got_a});
      end
    end
    prev_addr = rom_addr;
  end

  task automatic push_s(input logic [15:0] v);
    exp_ev.push_back({1'b0, v});
  endtask

  task automatic push_d();
    exp_ev.push_back({1'b1, 16'h0});
  endtask

  task automatic frame(input int half);
    @(negedge Clk) I2S_LRCLK = 1'b0;
    repeat (half) @(negedge Clk);
    I2S_LRCLK = 1'b1;
    repeat (half - 1) @(negedge Clk);
  endtask

  task automatic start(input logic [2:0] c, input logic l);
    @(negedge Clk);
    clip_sel = c;
    loop     = l;
    play     = 1'b1;
    @(negedge Clk);
    play = 1'b0;
  endtask

  task automatic drained(input string name);
    repeat (12) @(negedge Clk);
    check({name, "_ev_left"}, exp_ev.size(), 0);
    check({name, "_addr_left"}, exp_addr.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    mem[11'h200] = 16'h1234;
    mem[11'h201] = 16'hABCD;
    mem[11'h202] = 16'hFFFF;
    mem[11'h500] = 16'hFFFF;
    for (int i = 0; i < 256; i++) mem[11'h700 + i] = 16'h7000 + 16'(i);

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_rom_addr", {21'h0, rom_addr}, 0);
    check("rst_sample", {16'h0, sample}, 0);
    check("rst_valid", {31'h0, sample_valid}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_overrun", {31'h0, overrun}, 0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    // Clip 2, no loop
    exp_addr.push_back(11'h200); exp_addr.push_back(11'h201); exp_addr.push_back(11'h202);
    push_s(16'h1234); push_s(16'hABCD); push_d();
    start(3'd2, 1'b0);
    check("t1_busy", {31'h0, busy}, 1);
    repeat (3) frame(8);
    drained("t1");
    check("t1_busy_end", {31'h0, busy}, 0);
    check("t1_sample_hold", {16'h0, sample}, 32'hABCD);

    // Clip 2, looping: marker refetches the base in the same frame
    exp_addr.push_back(11'h200); exp_addr.push_back(11'h201); exp_addr.push_back(11'h202);
    exp_addr.push_back(11'h200); exp_addr.push_back(11'h201); exp_addr.push_back(11'h202);
    exp_addr.push_back(11'h200);
    push_s(16'h1234); push_s(16'hABCD); push_s(16'h1234); push_s(16'hABCD); push_s(16'h1234);
    start(3'd2, 1'b1);
    repeat (5) frame(8);
    drained("t2");
    check("t2_busy_loop", {31'h0, busy}, 1);
    @(negedge Clk) stop = 1'b1;
    loop = 1'b0;
    @(negedge Clk) stop = 1'b0;
    check("t2_stop_busy", {31'h0, busy}, 0);
    check("t2_stop_sample", {16'h0, sample}, 0);

    // Clip 5: empty clip ends even with loop
    exp_addr.push_back(11'h500);
    push_d();
    start(3'd5, 1'b1);
    frame(8);
    drained("t3");
    check("t3_busy", {31'h0, busy}, 0);
    loop = 1'b0;

    // Clip 7: full region with no marker
    for (int i = 0; i < 256; i++) begin
      exp_addr.push_back(11'h700 + 11'(i));
      push_s(16'h7000 + 16'(i));
    end
    push_d();
    start(3'd7, 1'b0);
    repeat (257) frame(8);
    drained("t4");
    check("t4_busy", {31'h0, busy}, 0);
    check("t4_sample", {16'h0, sample}, 32'h70FF);

    // Stop during WAIT
    exp_addr.push_back(11'h200);
    start(3'd2, 1'b0);
    @(negedge Clk) I2S_LRCLK = 1'b0;
    repeat (4) @(negedge Clk);
    check("t5_wait_addr", {21'h0, rom_addr}, 32'h200);
    stop = 1'b1;
    @(negedge Clk) stop = 1'b0;
    check("t5_stop_busy", {31'h0, busy}, 0);
    check("t5_stop_sample", {16'h0, sample}, 0);
    I2S_LRCLK = 1'b1;
    drained("t5a");

    // Stop and play together in IDLE
    @(negedge Clk);
    clip_sel = 3'd2;
    play = 1'b1;
    stop = 1'b1;
    @(negedge Clk);
    play = 1'b0;
    stop = 1'b0;
    check("t5b_busy", {31'h0, busy}, 0);
    frame(8);
    drained("t5b");

    // Play while busy is ignored
    exp_addr.push_back(11'h200); exp_addr.push_back(11'h201); exp_addr.push_back(11'h202);
    push_s(16'h1234); push_s(16'hABCD); push_d();
    start(3'd2, 1'b0);
    frame(8);
    start(3'd5, 1'b0);
    repeat (2) frame(8);
    drained("t5c");
    check("t5c_busy", {31'h0, busy}, 0);

    // Short LRCLK period: overrun, dropped ticks, no double fetch
    check("t6_overrun_pre", {31'h0, overrun}, 0);
    exp_addr.push_back(11'h200); exp_addr.push_back(11'h201); exp_addr.push_back(11'h202);
    push_s(16'h1234); push_s(16'hABCD); push_d();
    start(3'd2, 1'b0);
    repeat (10) frame(2);
    drained("t6");
    check("t6_overrun", {31'h0, overrun}, 1);
    check("t6_busy", {31'h0, busy}, 0);

    // Play clears overrun; asynchronous Reset mid-WAIT
    exp_addr.push_back(11'h200);
    start(3'd2, 1'b0);
    check("t7_overrun_clr", {31'h0, overrun}, 0);
    @(negedge Clk) I2S_LRCLK = 1'b0;
    repeat (4) @(negedge Clk);
    check("t7_wait_addr", {21'h0, rom_addr}, 32'h200);
    check("t7_wait_sample", {16'h0, sample}, 32'hABCD);
    #2 Reset = 1'b1;
    #1;
    check("t7_rst_addr", {21'h0, rom_addr}, 0);
    check("t7_rst_sample", {16'h0, sample}, 0);
    check("t7_rst_busy", {31'h0, busy}, 0);
    @(negedge Clk);
    Reset = 1'b0;
    I2S_LRCLK = 1'b1;
    drained("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
